fetch_stream: RTL

FETCH_STREAM -- requirements
Module: fetch_stream

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_word_sel.sv | 21 ++
 rtl/fetch_stream.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions: front-end state encoding and block geometry
// helpers, also used by the instruction cache.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } fetch_state_e;

  function automatic int block_size(input int word_size, input int block_words);
    return word_size * block_words;
  endfunction

  function automatic int block_bytes(input int word_size, input int block_words);
    return block_size(word_size, block_words) / 8;
  endfunction

  function automatic int offset_w(input int nbytes);
    return $clog2(nbytes);
  endfunction

endpackage

// File: rtl/fetch_word_sel.sv
// Combinational selection of one instruction word out of a cache block.
module fetch_word_sel
  import fetch_pkg::*;
#(
  parameter  int WORD_SIZE   = 32,
  parameter  int BLOCK_WORDS = 32,
  localparam int IDX_W       = $clog2(BLOCK_WORDS),
  localparam int BLOCK_SIZE  = block_size(WORD_SIZE, BLOCK_WORDS)
) (
  input  logic [BLOCK_SIZE-1:0] block_i,
  input  logic [IDX_W-1:0]      idx_i,
  output logic [WORD_SIZE-1:0]  word_o
);

  logic [BLOCK_WORDS-1:0][WORD_SIZE-1:0] words_s;

  assign words_s = block_i;
  // Word 0 sits at the MSB end, so word k is packed element BLOCK_WORDS-1-k, i.e. ~k.
  assign word_o  = words_s[~idx_i];

endmodule

// File: rtl/fetch_stream.sv
// Instruction fetch front end: requests whole cache blocks and streams their
// words to decode, with redirect handling and at most one request in flight.
module fetch_stream
  import fetch_pkg::*;
#(
  parameter  int                WORD_SIZE   = 32,
  parameter  int                BLOCK_WORDS = 32,
  parameter  int                ADDR_W      = 32,
  parameter  logic [ADDR_W-1:0] RESET_PC    = '0,
  localparam int                BLOCK_SIZE  = block_size(WORD_SIZE, BLOCK_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [ADDR_W-1:0]     redirect_pc,
  output logic                  icache_req_valid,
  output logic [ADDR_W-1:0]     icache_req_addr,
  input  logic                  icache_req_ready,
  input  logic                  icache_resp_valid,
  input  logic [BLOCK_SIZE-1:0] icache_resp_block,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [WORD_SIZE-1:0]  inst_data,
  output logic [ADDR_W-1:0]     inst_pc
);

  localparam int                BLOCK_BYTES = block_bytes(WORD_SIZE, BLOCK_WORDS);
  localparam int                IDX_W       = $clog2(BLOCK_WORDS);
  localparam int                WB_W        = offset_w(WORD_SIZE / 8);
  localparam int                OFF_W       = offset_w(BLOCK_BYTES);
  localparam logic [ADDR_W-1:0] WORD_MASK   = ~((ADDR_W'(1) << WB_W) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] BLOCK_MASK  = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] BLOCK_STEP  = ADDR_W'(BLOCK_BYTES);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(BLOCK_WORDS - 1);

  fetch_state_e          state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BLOCK_SIZE-1:0] buf_q, buf_d;
  logic [ADDR_W-1:0]     base_s;
  logic [ADDR_W-1:0]     redir_pc_s;
  logic [WORD_SIZE-1:0]  word_s;

  assign base_s     = pc_q & BLOCK_MASK;
  assign redir_pc_s = redirect_pc & WORD_MASK;

  fetch_word_sel #(
    .WORD_SIZE  (WORD_SIZE),
    .BLOCK_WORDS(BLOCK_WORDS)
  ) u_word_sel (
    .block_i(buf_q),
    .idx_i  (idx_q),
    .word_o (word_s)
  );

  // Outputs depend only on registered state; instruction fields read zero when not valid.
  assign icache_req_valid = (state_q == ST_REQ);
  assign icache_req_addr  = base_s;
  assign inst_valid       = (state_q == ST_STREAM);
  assign inst_data        = inst_valid ? word_s : '0;
  assign inst_pc          = inst_valid ? (base_s | (ADDR_W'(idx_q) << WB_W)) : '0;

  // Next-state logic; redirect outranks every other event in every state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    case (state_q)
      ST_REQ: begin
        if (redirect_valid) begin
          pc_d    = redir_pc_s;
          state_d = icache_req_ready ? ST_DRAIN : ST_REQ;
        end else if (icache_req_ready) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        // A response arriving with the redirect is the stale one, so nothing is left to drain.
        if (redirect_valid) begin
          pc_d    = redir_pc_s;
          state_d = icache_resp_valid ? ST_REQ : ST_DRAIN;
        end else if (icache_resp_valid) begin
          buf_d   = icache_resp_block;
          idx_d   = IDX_W'(pc_q >> WB_W);
          state_d = ST_STREAM;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_STREAM: begin
        if (redirect_valid) begin
          pc_d    = redir_pc_s;
          state_d = ST_REQ;
        end else if (inst_valid && inst_ready) begin
          if (idx_q == LAST_IDX) begin
            pc_d    = base_s + BLOCK_STEP;
            state_d = ST_REQ;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_STREAM;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        if (redirect_valid) begin
          pc_d = redir_pc_s;
        end else begin
          pc_d = pc_q;
        end
        if (icache_resp_valid) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  // State, fetch pointer, word index and block buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

endmodule
